serial_subtractor: RTL

- Bit-serial unsigned N-bit subtractor computing a - b one bit per clock, LSB first. The single borrow flip-flop is fed back into a full-subtractor cell built from two half-subtractor stages.
- Sits downstream of the half-subtractor cell and consumes its diff/borrow outputs across cycles, trading area for latency.
- Uses a start/busy/done handshake so a controller or bench can launch operations and collect registered results.

---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
//   clock, LSB first. A single borrow flop is fed back into a full-subtractor
//   cell made of two half-subtractor stages.
//
//   Ports:
//     clk        - system clock, rising edge
//     rst_n      - synchronous active-low reset
//     start      - launch request, honoured only when not busy
//     a, b       - minuend / subtrahend, captured on the accepted start edge
//     busy       - high while bits are being processed
//     done       - one-cycle pulse marking a valid result
//     diff       - registered result (a - b) mod 2^WIDTH
//     borrow_out - final borrow, 1 iff a < b
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for start
//   SHIFT   | processing one bit per clock (busy)
//   DONE    | result valid, done pulse; start accepted here too

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Full subtractor built from two half-subtractor stages.
  logic ai, bi;
  logic hs1_d, hs1_b;
  logic hs2_d, hs2_b;
  logic bnext;

  assign ai    = a_sh_q[0];
  assign bi    = b_sh_q[0];
  assign hs1_d = ai ^ bi;
  assign hs1_b = ~ai & bi;
  assign hs2_d = hs1_d ^ brw_q;
  assign hs2_b = ~hs1_d & brw_q;
  assign bnext = hs1_b | hs2_b;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Result enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        res_d  = {hs2_d, res_q[WIDTH-1:1]};
        brw_d  = bnext;
        // Wraps only on the completion edge, after which it is reloaded on start.
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          diff_d  = res_d;
          bout_d  = bnext;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
